sd_init_seq: RTL and testbench
==============================

# sd_init_seq

Hardware sequencer for SD card SPI-mode initialisation. It drives the command interface of `SDctrl`: cmd, address, en, en_clk, div_clk and i_cs. It runs power-up clocks, then CMD0, CMD8, and the CMD55/ACMD41 loop, and finally switches SCK to the fast divider. It sits between the UART register bank and `SDctrl`, so host software issues one start instead of hand-sequencing each command.

## Interface
Parameters:
- `SLOW_DIV`, 8'hff: div_clk value during initialisation (≤400 kHz SCK).
- `FAST_DIV`, 8'h02: div_clk value applied after success.
- `PWRUP_CYCLES`, 20000: clk cycles with cs high and SCK running before CMD0 (≥74 SCK at SLOW_DIV).
- `RESP_TIMEOUT`, 1000000: clk cycles allowed from sd_en rise to sd_valid_status.
- `MAX_RETRY`, 1000: maximum ACMD41 attempts.
- `RETRY_GAP`, 96000: idle clk cycles between ACMD41 attempts.

Ports:
- `clk`, in, 1: system clock (clk96m). One clock; asynchronous active-low reset.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle request to begin initialisation.
- `abort`, in, 1: single-cycle request to stop and return to idle.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: sticky success flag, cleared by the next accepted start.
- `error`, out, 1: sticky failure flag, cleared by the next accepted start.
- `err_code`, out, 3: 1 = CMD0 bad response, 2 = CMD8 bad, 3 = CMD55 bad, 4 = ACMD41 bad, 5 = retries exhausted, 6 = timeout, 7 = aborted.
- `card_v2`, out, 1: CMD8 accepted (status 0x01).
- `sd_cmd`, out, 7: command index to `SDctrl`.
- `sd_address`, out, 32: command argument.
- `sd_en`, out, 1: command request, held until status is received.
- `sd_en_clk`, out, 1: SCK enable.
- `sd_div_clk`, out, 8: SCK divider.
- `sd_cs`, out, 1: chip-select level to `SDctrl` i_cs.
- `sd_rdy`, in, 1: `SDctrl` idle.
- `sd_valid_status`, in, 1: single-cycle strobe indicating an R1 response.
- `sd_resp_status`, in, 7: R1 status bits.

## Operation
States: IDLE, PWRUP, ISSUE, WAIT_RESP, RELEASE, GAP, DONE_S.

- **IDLE:** `start` moves to PWRUP, sets busy, and clears done, error, err_code and card_v2. `start` is ignored in all other states.
- **PWRUP:** sd_cs=1, sd_en_clk=1, sd_div_clk=SLOW_DIV. Count PWRUP_CYCLES, then set sd_cs=0 and go to ISSUE with CMD0, arg 0.
- **ISSUE:** wait for sd_rdy=1. Then drive sd_cmd/sd_address and assert sd_en on the next edge. Clear the timeout counter and go to WAIT_RESP.
- **WAIT_RESP:** on sd_valid_status, capture status, deassert sd_en, and go to RELEASE. If the timeout counter reaches RESP_TIMEOUT first, fail with code 6.
- **RELEASE:** wait for sd_rdy=1, then evaluate the captured status:
  - CMD0: 0x01 → CMD8 with arg 0x000001AA; anything else → fail 1.
  - CMD8: 0x01 → card_v2=1; 0x05 → card_v2=0; either → CMD55 with arg 0. Anything else → fail 2.
  - CMD55: 0x00 or 0x01 → ACMD41 (sd_cmd=41) with arg 0x40000000 if card_v2, else 0. Anything else → fail 3.
  - ACMD41: 0x00 → DONE_S. 0x01 → increment the retry counter; if it equals MAX_RETRY, fail 5, otherwise go to GAP. Anything else → fail 4.
- **GAP:** count RETRY_GAP, then go to ISSUE with CMD55.
- **DONE_S:** set sd_div_clk=FAST_DIV, done=1, busy=0, and return to IDLE. sd_cs stays 0 and sd_en_clk stays 1.
- **fail:** set error=1 and err_code, busy=0, sd_en=0, sd_cs=1, sd_div_clk=SLOW_DIV; go to IDLE.
- **abort:** in any non-IDLE state, behave as fail with code 7 on the next edge. If start and abort arrive together in IDLE, abort wins: nothing starts and no flags change. sd_valid_status outside WAIT_RESP is ignored.
- **Width rules:** counters are sized with $clog2 of their parameter and saturate; they never wrap.

## Timing
- **Reset values:** sd_cmd=0, sd_address=0, sd_en=0, sd_en_clk=0, sd_div_clk=SLOW_DIV, sd_cs=1, busy=0, done=0, error=0, err_code=0, card_v2=0.
- Reset asserted mid-sequence forces the reset values immediately, with sd_en dropping asynchronously.
- busy rises on the edge after start is sampled.
- sd_cmd/sd_address are stable from the edge that raises sd_en until the edge after sd_valid_status.
- sd_en falls on the edge after the sd_valid_status strobe.
- Status capture to next-command sd_en: ≥2 cycles (RELEASE, then ISSUE).
- The PWRUP to CMD0 transition takes exactly PWRUP_CYCLES+1 cycles after busy rises.
- done and error update on the same edge that busy falls.

## Structure
- Shared package `sd_pkg`: state encodings, command-index constants (CMD0=0, CMD8=8, CMD55=55, ACMD41=41), CMD8 and ACMD41 argument constants, err_code values.
- Single module, no sub-modules. One shared down-counter is reused for PWRUP, the timeout and GAP; the retry counter is separate.

## Test plan
Bench uses a behavioural `SDctrl` model that answers after a programmable delay.
- Model replies 0x01, 0x01, 0x01, then 0x00 to ACMD41 on the 3rd try → done=1, card_v2=1, sd_div_clk=8'h02, three CMD55/ACMD41 pairs seen, ACMD41 arg 0x40000000.
- CMD8 reply 0x05 → card_v2=0, ACMD41 arg 0, done=1.
- CMD0 reply 0x00 → error=1, err_code=1, sd_cs=1, sd_en=0.
- Model never strobes sd_valid_status (RESP_TIMEOUT=50) → err_code=6 exactly 51 cycles after sd_en rises.
- ACMD41 always replies 0x01 with MAX_RETRY=3 → err_code=5 after 3 attempts.
- abort during GAP, then start one cycle later → err_code=7, then a clean re-run completes; rst_n pulsed in WAIT_RESP → all outputs return to reset values immediately.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD card SPI-mode initialisation sequencer.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_ISSUE,
    S_WAIT_RESP,
    S_RELEASE,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [6:0] CMD0   = 7'd0;
  localparam logic [6:0] CMD8   = 7'd8;
  localparam logic [6:0] CMD55  = 7'd55;
  localparam logic [6:0] ACMD41 = 7'd41;

  localparam logic [31:0] ARG_NONE       = 32'h0000_0000;
  localparam logic [31:0] ARG_CMD8       = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41_HCS = 32'h4000_0000;

  // R1 values the sequence accepts: ready, idle, idle + illegal command (v1 card on CMD8).
  localparam logic [6:0] R1_READY        = 7'h00;
  localparam logic [6:0] R1_IDLE         = 7'h01;
  localparam logic [6:0] R1_IDLE_ILLEGAL = 7'h05;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_CMD0    = 3'd1,
    ERR_CMD8    = 3'd2,
    ERR_CMD55   = 3'd3,
    ERR_ACMD41  = 3'd4,
    ERR_RETRY   = 3'd5,
    ERR_TIMEOUT = 3'd6,
    ERR_ABORT   = 3'd7
  } err_t;

  function automatic int cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(longint'(n) + 1);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sd_init_seq.sv
// Drives SDctrl through power-up clocks, CMD0, CMD8 and the CMD55/ACMD41 loop,
// then switches SCK to the fast divider.
module sd_init_seq
  import sd_pkg::*;
#(
  parameter logic [7:0]  SLOW_DIV     = 8'hff,
  parameter logic [7:0]  FAST_DIV     = 8'h02,
  parameter int unsigned PWRUP_CYCLES = 20000,
  parameter int unsigned RESP_TIMEOUT = 1000000,
  parameter int unsigned MAX_RETRY    = 1000,
  parameter int unsigned RETRY_GAP    = 96000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        card_v2,
  output logic [6:0]  sd_cmd,
  output logic [31:0] sd_address,
  output logic        sd_en,
  output logic        sd_en_clk,
  output logic [7:0]  sd_div_clk,
  output logic        sd_cs,
  input  logic        sd_rdy,
  input  logic        sd_valid_status,
  input  logic [6:0]  sd_resp_status
);

  // One down-counter serves power-up, response timeout and retry gap.
  localparam int CNT_W = cnt_width(max3(PWRUP_CYCLES, RESP_TIMEOUT, RETRY_GAP));
  localparam int RTY_W = cnt_width(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry;
  logic [RTY_W-1:0] retry_inc;
  logic [6:0]       status;
  logic [6:0]       next_cmd;
  logic [31:0]      next_arg;
  logic             fail;
  err_t             fail_code;

  assign retry_inc = (retry == RTY_W'(MAX_RETRY)) ? retry : retry + 1'b1;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (state != S_IDLE && abort) begin
      fail      = 1'b1;
      fail_code = ERR_ABORT;
    end else begin
      case (state)
        S_WAIT_RESP: begin
          if (!sd_valid_status && cnt == '0) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
          end
        end
        S_RELEASE: begin
          if (sd_rdy) begin
            case (sd_cmd)
              CMD0: begin
                if (status != R1_IDLE) begin
                  fail      = 1'b1;
                  fail_code = ERR_CMD0;
                end
              end
              CMD8: begin
                if (status != R1_IDLE && status != R1_IDLE_ILLEGAL) begin
                  fail      = 1'b1;
                  fail_code = ERR_CMD8;
                end
              end
              CMD55: begin
                if (status > R1_IDLE) begin
                  fail      = 1'b1;
                  fail_code = ERR_CMD55;
                end
              end
              default: begin
                if (status > R1_IDLE) begin
                  fail      = 1'b1;
                  fail_code = ERR_ACMD41;
                end else if (status == R1_IDLE && retry_inc == RTY_W'(MAX_RETRY)) begin
                  fail      = 1'b1;
                  fail_code = ERR_RETRY;
                end
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      retry      <= '0;
      status     <= '0;
      next_cmd   <= CMD0;
      next_arg   <= ARG_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= ERR_NONE;
      card_v2    <= 1'b0;
      sd_cmd     <= '0;
      sd_address <= '0;
      sd_en      <= 1'b0;
      sd_en_clk  <= 1'b0;
      sd_div_clk <= SLOW_DIV;
      sd_cs      <= 1'b1;
    end else if (fail) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      error      <= 1'b1;
      err_code   <= fail_code;
      sd_en      <= 1'b0;
      sd_cs      <= 1'b1;
      sd_div_clk <= SLOW_DIV;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state      <= S_PWRUP;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
            card_v2    <= 1'b0;
            retry      <= '0;
            cnt        <= CNT_W'(PWRUP_CYCLES);
            sd_cs      <= 1'b1;
            sd_en_clk  <= 1'b1;
            sd_div_clk <= SLOW_DIV;
          end
        end
        S_PWRUP: begin
          if (cnt == '0) begin
            sd_cs    <= 1'b0;
            next_cmd <= CMD0;
            next_arg <= ARG_NONE;
            state    <= S_ISSUE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_ISSUE: begin
          if (sd_rdy) begin
            sd_cmd     <= next_cmd;
            sd_address <= next_arg;
            sd_en      <= 1'b1;
            cnt        <= CNT_W'(RESP_TIMEOUT);
            state      <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (sd_valid_status) begin
            status <= sd_resp_status;
            sd_en  <= 1'b0;
            state  <= S_RELEASE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RELEASE: begin
          // Failing responses were already diverted above; only the success paths remain.
          if (sd_rdy) begin
            case (sd_cmd)
              CMD0: begin
                next_cmd <= CMD8;
                next_arg <= ARG_CMD8;
                state    <= S_ISSUE;
              end
              CMD8: begin
                card_v2  <= (status == R1_IDLE);
                next_cmd <= CMD55;
                next_arg <= ARG_NONE;
                state    <= S_ISSUE;
              end
              CMD55: begin
                next_cmd <= ACMD41;
                next_arg <= card_v2 ? ARG_ACMD41_HCS : ARG_NONE;
                state    <= S_ISSUE;
              end
              default: begin
                if (status == R1_READY) begin
                  state <= S_DONE;
                end else begin
                  retry <= retry_inc;
                  cnt   <= CNT_W'(RETRY_GAP);
                  state <= S_GAP;
                end
              end
            endcase
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            next_cmd <= CMD55;
            next_arg <= ARG_NONE;
            state    <= S_ISSUE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          sd_div_clk <= FAST_DIV;
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq: a behavioural SDctrl replies from a queue while a
// monitor checks every issued command and every run outcome against queued expectations.
module tb_sd_init_seq;
  import sd_pkg::*;

  localparam int unsigned PWRUP = 10;
  localparam int unsigned TMO   = 50;
  localparam int unsigned RETRY = 3;
  localparam int unsigned GAP   = 6;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy, done, error, card_v2;
  logic [2:0]  err_code;
  logic [6:0]  sd_cmd;
  logic [31:0] sd_address;
  logic        sd_en, sd_en_clk, sd_cs;
  logic [7:0]  sd_div_clk;
  logic        sd_rdy;
  logic        sd_valid_status;
  logic [6:0]  sd_resp_status;

  typedef struct {
    logic [6:0]  cmd;
    logic [31:0] arg;
  } cmd_exp_t;

  typedef struct {
    logic       done;
    logic       error;
    logic [2:0] code;
    logic       v2;
    logic [7:0] div;
    logic       cs;
    int         lat;
  } end_exp_t;

  cmd_exp_t   cmd_q[$];
  end_exp_t   end_q[$];
  logic [6:0] rsp_q[$];
  bit         mute      = 1'b0;
  int         rsp_delay = 3;
  int         n_cmp     = 0;
  int         n_bad     = 0;

  always #5 clk = ~clk;

  sd_init_seq #(
    .SLOW_DIV    (8'hff),
    .FAST_DIV    (8'h02),
    .PWRUP_CYCLES(PWRUP),
    .RESP_TIMEOUT(TMO),
    .MAX_RETRY   (RETRY),
    .RETRY_GAP   (GAP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .card_v2        (card_v2),
    .sd_cmd         (sd_cmd),
    .sd_address     (sd_address),
    .sd_en          (sd_en),
    .sd_en_clk      (sd_en_clk),
    .sd_div_clk     (sd_div_clk),
    .sd_cs          (sd_cs),
    .sd_rdy         (sd_rdy),
    .sd_valid_status(sd_valid_status),
    .sd_resp_status (sd_resp_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [6:0] c, input logic [31:0] a);
    cmd_exp_t e;
    e.cmd = c;
    e.arg = a;
    cmd_q.push_back(e);
  endtask

  task automatic exp_end(input logic d, input logic er, input logic [2:0] code, input logic v2,
                         input logic [7:0] div, input logic cs, input int lat);
    end_exp_t e;
    e.done  = d;
    e.error = er;
    e.code  = code;
    e.v2    = v2;
    e.div   = div;
    e.cs    = cs;
    e.lat   = lat;
    end_q.push_back(e);
  endtask

  task automatic reply(input logic [6:0] s);
    rsp_q.push_back(s);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0) break;
      @(posedge clk); #1;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still high after cycle budget", name);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Behavioural SDctrl: drops rdy on a request, answers after rsp_delay cycles unless muted.
  initial begin : sd_model
    sd_rdy          = 1'b1;
    sd_valid_status = 1'b0;
    sd_resp_status  = '0;
    forever begin
      @(posedge clk); #1;
      if (sd_en === 1'b1 && sd_rdy) begin
        sd_rdy = 1'b0;
        repeat (rsp_delay) begin @(posedge clk); #1; end
        if (!mute && sd_en === 1'b1 && rsp_q.size() > 0) begin
          sd_resp_status  = rsp_q.pop_front();
          sd_valid_status = 1'b1;
          @(posedge clk); #1;
          sd_valid_status = 1'b0;
        end
        for (int i = 0; i < 200 && sd_en === 1'b1; i++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        sd_rdy = 1'b1;
      end
    end
  end

  initial begin : reset_monitor
    forever begin
      @(negedge rst_n); #1;
      check("rst_sd_cmd",     32'(sd_cmd),     32'h0);
      check("rst_sd_address", sd_address,      32'h0);
      check("rst_sd_en",      32'(sd_en),      32'h0);
      check("rst_sd_en_clk",  32'(sd_en_clk),  32'h0);
      check("rst_sd_div_clk", 32'(sd_div_clk), 32'hff);
      check("rst_sd_cs",      32'(sd_cs),      32'h1);
      check("rst_busy",       32'(busy),       32'h0);
      check("rst_done",       32'(done),       32'h0);
      check("rst_error",      32'(error),      32'h0);
      check("rst_err_code",   32'(err_code),   32'h0);
      check("rst_card_v2",    32'(card_v2),    32'h0);
    end
  end

  initial begin : monitor
    logic     prev_en, prev_busy, prev_cs;
    int       cyc, en_cyc, busy_cyc;
    cmd_exp_t ce;
    end_exp_t ee;
    prev_en = 1'b0; prev_busy = 1'b0; prev_cs = 1'b1;
    cyc = 0; en_cyc = 0; busy_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        prev_en = 1'b0; prev_busy = 1'b0; prev_cs = 1'b1;
      end else begin
        if (sd_en === 1'b1 && !prev_en) begin
          en_cyc = cyc;
          if (cmd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_unexpected: got cmd %0d arg 0x%0h, none expected", sd_cmd, sd_address);
          end else begin
            ce = cmd_q.pop_front();
            check("cmd_index", 32'(sd_cmd), 32'(ce.cmd));
            check("cmd_arg",   sd_address,  ce.arg);
          end
        end
        if (busy === 1'b1 && !prev_busy) busy_cyc = cyc;
        if (sd_cs === 1'b0 && prev_cs && busy === 1'b1)
          check("pwrup_len", 32'(cyc - busy_cyc), PWRUP + 1);
        if (busy === 1'b0 && prev_busy) begin
          if (end_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL end_unexpected: run ended with error=%0b code=%0d, none expected", error, err_code);
          end else begin
            ee = end_q.pop_front();
            check("end_done",    32'(done),       32'(ee.done));
            check("end_error",   32'(error),      32'(ee.error));
            check("end_code",    32'(err_code),   32'(ee.code));
            check("end_card_v2", 32'(card_v2),    32'(ee.v2));
            check("end_div",     32'(sd_div_clk), 32'(ee.div));
            check("end_cs",      32'(sd_cs),      32'(ee.cs));
            check("end_sd_en",   32'(sd_en),      32'h0);
            if (ee.done) check("end_en_clk", 32'(sd_en_clk), 32'h1);
            if (ee.lat >= 0) check("end_latency", 32'(cyc - en_cyc), 32'(ee.lat));
          end
        end
        prev_en = sd_en; prev_busy = busy; prev_cs = sd_cs;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // v2 card, ACMD41 ready on the third attempt.
    reply(7'h01); reply(7'h01);
    for (int i = 0; i < 3; i++) begin
      reply(7'h01);
      reply((i == 2) ? 7'h00 : 7'h01);
    end
    exp_cmd(7'd0, 32'h0); exp_cmd(7'd8, 32'h0000_01AA);
    for (int i = 0; i < 3; i++) begin
      exp_cmd(7'd55, 32'h0); exp_cmd(7'd41, 32'h4000_0000);
    end
    exp_end(1'b1, 1'b0, 3'd0, 1'b1, 8'h02, 1'b0, -1);
    pulse_start();
    wait_idle("v2_run");

    // start together with abort in IDLE is ignored.
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_wins_busy", 32'(busy),       32'h0);
    check("abort_wins_done", 32'(done),       32'h1);
    check("abort_wins_div",  32'(sd_div_clk), 32'h02);

    // v1 card: CMD8 answers illegal-command.
    reply(7'h01); reply(7'h05); reply(7'h00); reply(7'h00);
    exp_cmd(7'd0, 32'h0); exp_cmd(7'd8, 32'h0000_01AA); exp_cmd(7'd55, 32'h0); exp_cmd(7'd41, 32'h0);
    exp_end(1'b1, 1'b0, 3'd0, 1'b0, 8'h02, 1'b0, -1);
    pulse_start();
    wait_idle("v1_run");

    // CMD0 not answered with idle.
    reply(7'h00);
    exp_cmd(7'd0, 32'h0);
    exp_end(1'b0, 1'b1, 3'd1, 1'b0, 8'hff, 1'b1, -1);
    pulse_start();
    wait_idle("cmd0_bad");

    // No response at all: timeout 51 cycles after sd_en rises.
    mute = 1'b1;
    exp_cmd(7'd0, 32'h0);
    exp_end(1'b0, 1'b1, 3'd6, 1'b0, 8'hff, 1'b1, 51);
    pulse_start();
    wait_idle("timeout");
    mute = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // ACMD41 stays idle until the retry budget runs out.
    reply(7'h01); reply(7'h01);
    exp_cmd(7'd0, 32'h0); exp_cmd(7'd8, 32'h0000_01AA);
    for (int i = 0; i < 3; i++) begin
      reply(7'h01); reply(7'h01);
      exp_cmd(7'd55, 32'h0); exp_cmd(7'd41, 32'h4000_0000);
    end
    exp_end(1'b0, 1'b1, 3'd5, 1'b1, 8'hff, 1'b1, -1);
    pulse_start();
    wait_idle("retry_exhausted");

    // Abort in GAP, restart one cycle later, clean v1 completion.
    reply(7'h01); reply(7'h01); reply(7'h01); reply(7'h01);
    exp_cmd(7'd0, 32'h0); exp_cmd(7'd8, 32'h0000_01AA); exp_cmd(7'd55, 32'h0); exp_cmd(7'd41, 32'h4000_0000);
    exp_end(1'b0, 1'b1, 3'd7, 1'b1, 8'hff, 1'b1, -1);
    exp_cmd(7'd0, 32'h0); exp_cmd(7'd8, 32'h0000_01AA); exp_cmd(7'd55, 32'h0); exp_cmd(7'd41, 32'h0);
    exp_end(1'b1, 1'b0, 3'd0, 1'b0, 8'h02, 1'b0, -1);
    pulse_start();
    for (int i = 0; i < 500 && dut.state != S_GAP; i++) begin @(posedge clk); #1; end
    if (dut.state != S_GAP) begin
      n_cmp++;
      n_bad++;
      $display("FAIL gap_reach: sequencer never entered the retry gap");
    end
    reply(7'h01); reply(7'h05); reply(7'h01); reply(7'h00);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("abort_rerun");

    // Reset pulse while a command waits for its response.
    mute = 1'b1;
    exp_cmd(7'd0, 32'h0);
    pulse_start();
    for (int i = 0; i < 200 && sd_en !== 1'b1; i++) begin @(posedge clk); #1; end
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mute = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    check("cmd_q_left", 32'(cmd_q.size()), 32'h0);
    check("end_q_left", 32'(end_q.size()), 32'h0);
    check("rsp_q_left", 32'(rsp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
